// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router packet reader slice.
// FSM encoding, header field layout and router timing constants.
package router_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE     = 2'd0;
   localparam state_t S_HDR_REQ  = 2'd1;
   localparam state_t S_HDR_WAIT = 2'd2;
   localparam state_t S_BODY     = 2'd3;

   localparam int ADDR_LSB = 0;
   localparam int ADDR_W   = 2;
   localparam int LEN_LSB  = 2;
   localparam int LEN_W    = 6;

   // Router FIFO soft-reset fires after this many stalled cycles.
   localparam int SOFT_RST_CYC = 30;

   // Bytes still owed after the header: payload plus parity.
   function automatic logic [6:0] hdr_count(input logic [7:0] hdr);
      return {1'b0, hdr[LEN_LSB +: LEN_W]} + 7'd1;
   endfunction

endpackage

// File: rtl/router_pkt_checker.sv
// router_pkt_checker: parity accumulator, parity compare and packet/error counters.
// Ports: clk, reset, hdr_cap/pld_cap/par_cap/tmo strobes, data byte -> pkt_done, parity_err, timeout_err, pkt_cnt, err_cnt.
module router_pkt_checker (
   input  logic        clk,
   input  logic        reset,
   input  logic        hdr_cap,
   input  logic        pld_cap,
   input  logic        par_cap,
   input  logic        tmo,
   input  logic [7:0]  data,
   output logic        pkt_done,
   output logic        parity_err,
   output logic        timeout_err,
   output logic [15:0] pkt_cnt,
   output logic [7:0]  err_cnt
);

   logic [7:0] acc;
   logic       mis;

   assign mis = par_cap && (data != acc);

   always_ff @(posedge clk) begin
      if (reset) begin
         acc         <= '0;
         pkt_done    <= 1'b0;
         parity_err  <= 1'b0;
         timeout_err <= 1'b0;
         pkt_cnt     <= '0;
         err_cnt     <= '0;
      end else begin
         pkt_done    <= par_cap;
         parity_err  <= mis;
         timeout_err <= tmo;
         if (hdr_cap)
            acc <= data;
         else if (pld_cap)
            acc <= acc ^ data;
         if (par_cap)
            pkt_cnt <= pkt_cnt + 16'd1;
         // mis and tmo are exclusive: a timeout needs a cycle without capture
         if ((mis || tmo) && (err_cnt != 8'hff))
            err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/router_pkt_reader.sv
// router_pkt_reader: read end of a router FIFO; parses header, payload and parity.
// Ports: clk, reset, vld_out, data_out, enable -> read_enb, pkt_start, hdr_addr, hdr_len, pld_data, pld_valid, pkt_done, parity_err, timeout_err, pkt_cnt, err_cnt.
module router_pkt_reader
   import router_pkg::*;
#(
   parameter int START_DELAY = 0,
   parameter int TIMEOUT     = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vld_out,
   input  logic [7:0]  data_out,
   input  logic        enable,
   output logic        read_enb,
   output logic        pkt_start,
   output logic [1:0]  hdr_addr,
   output logic [5:0]  hdr_len,
   output logic [7:0]  pld_data,
   output logic        pld_valid,
   output logic        pkt_done,
   output logic        parity_err,
   output logic        timeout_err,
   output logic [15:0] pkt_cnt,
   output logic [7:0]  err_cnt
);

   localparam logic [5:0] DLY = 6'(START_DELAY);
   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t     state;
   logic [5:0] dly_cnt;
   logic       rx_pend;
   logic [6:0] req_left;
   logic [6:0] rx_left;
   logic [7:0] idle_cnt;
   logic       rd;
   logic       busy;
   logic       hdr_cap;
   logic       pld_cap;
   logic       par_cap;
   logic       tmo;

   always_comb begin
      rd = 1'b0;
      unique case (state)
         S_HDR_REQ: rd = vld_out && enable;
         S_BODY:    rd = vld_out && enable && (req_left != 7'd0);
         default:   rd = 1'b0;
      endcase
      // a byte read under reset would be thrown away
      if (reset)
         rd = 1'b0;
   end

   assign read_enb = rd;

   assign busy    = (state == S_HDR_WAIT) || (state == S_BODY);
   assign hdr_cap = rx_pend && (state == S_HDR_WAIT);
   assign pld_cap = rx_pend && (state == S_BODY) && (rx_left > 7'd1);
   assign par_cap = rx_pend && (state == S_BODY) && (rx_left == 7'd1);
   // fires on the TIMEOUT-th consecutive cycle with no read and no capture
   assign tmo     = busy && !rd && !rx_pend && ((idle_cnt + 8'd1) == TMO);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         dly_cnt   <= '0;
         rx_pend   <= 1'b0;
         req_left  <= '0;
         rx_left   <= '0;
         idle_cnt  <= '0;
         pkt_start <= 1'b0;
         hdr_addr  <= '0;
         hdr_len   <= '0;
         pld_data  <= '0;
         pld_valid <= 1'b0;
      end else begin
         rx_pend   <= rd;
         pkt_start <= hdr_cap;
         pld_valid <= pld_cap;
         if (pld_cap)
            pld_data <= data_out;
         if (busy && !rd && !rx_pend && !tmo)
            idle_cnt <= idle_cnt + 8'd1;
         else
            idle_cnt <= '0;
         unique case (state)
            S_IDLE: begin
               if (!vld_out) begin
                  dly_cnt <= '0;
               end else if (dly_cnt == DLY) begin
                  dly_cnt <= '0;
                  state   <= S_HDR_REQ;
               end else begin
                  dly_cnt <= dly_cnt + 6'd1;
               end
            end
            S_HDR_REQ: begin
               if (rd)
                  state <= S_HDR_WAIT;
            end
            S_HDR_WAIT: begin
               if (hdr_cap) begin
                  hdr_addr <= data_out[ADDR_LSB +: ADDR_W];
                  hdr_len  <= data_out[LEN_LSB +: LEN_W];
                  req_left <= hdr_count(data_out);
                  rx_left  <= hdr_count(data_out);
                  state    <= S_BODY;
               end else if (tmo) begin
                  state <= S_IDLE;
               end
            end
            S_BODY: begin
               if (rd)
                  req_left <= req_left - 7'd1;
               if (rx_pend)
                  rx_left <= rx_left - 7'd1;
               if (par_cap || tmo)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   router_pkt_checker u_chk (
      .clk         (clk),
      .reset       (reset),
      .hdr_cap     (hdr_cap),
      .pld_cap     (pld_cap),
      .par_cap     (par_cap),
      .tmo         (tmo),
      .data        (data_out),
      .pkt_done    (pkt_done),
      .parity_err  (parity_err),
      .timeout_err (timeout_err),
      .pkt_cnt     (pkt_cnt),
      .err_cnt     (err_cnt)
   );

endmodule

// File: tb/tb_router_pkt_reader.sv
// tb_router_pkt_reader: FIFO model plus event-queue reference for router_pkt_reader.
// Second instance exercises the START_DELAY / soft-reset path.
module tb_router_pkt_reader;

   localparam int TMO = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vld_out = 1'b0;
   logic [7:0]  data_out = 8'h00;
   logic        enable = 1'b1;
   logic        read_enb, pkt_start, pld_valid, pkt_done, parity_err, timeout_err;
   logic [1:0]  hdr_addr;
   logic [5:0]  hdr_len;
   logic [7:0]  pld_data, err_cnt;
   logic [15:0] pkt_cnt;

   logic        vld2 = 1'b0;
   logic [7:0]  dat2 = 8'h00;
   logic        en2 = 1'b1;
   logic        read_enb2, pkt_start2, pld_valid2, pkt_done2, parity_err2, timeout_err2;
   logic [1:0]  hdr_addr2;
   logic [5:0]  hdr_len2;
   logic [7:0]  pld_data2, err_cnt2;
   logic [15:0] pkt_cnt2;

   router_pkt_reader #(.START_DELAY(0), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .vld_out(vld_out), .data_out(data_out),
      .enable(enable), .read_enb(read_enb), .pkt_start(pkt_start),
      .hdr_addr(hdr_addr), .hdr_len(hdr_len), .pld_data(pld_data),
      .pld_valid(pld_valid), .pkt_done(pkt_done), .parity_err(parity_err),
      .timeout_err(timeout_err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
   );

   router_pkt_reader #(.START_DELAY(31), .TIMEOUT(TMO)) dut2 (
      .clk(clk), .reset(reset), .vld_out(vld2), .data_out(dat2),
      .enable(en2), .read_enb(read_enb2), .pkt_start(pkt_start2),
      .hdr_addr(hdr_addr2), .hdr_len(hdr_len2), .pld_data(pld_data2),
      .pld_valid(pld_valid2), .pkt_done(pkt_done2), .parity_err(parity_err2),
      .timeout_err(timeout_err2), .pkt_cnt(pkt_cnt2), .err_cnt(err_cnt2)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         kind;
      logic [7:0] a;
      logic [7:0] b;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] fifo[$];

   int   nchk = 0, nerr = 0;
   int   tcyc = 0, ccyc = 0, last_ev = 0;
   int   npld = 0, nrd = 0;
   int   m_pkt = 0, m_err = 0;
   logic [1:0] m_addr = 2'd0;
   logic [5:0] m_len = 6'd0;
   logic rst_q = 1'b1;
   logic pend_valid = 1'b0;
   logic [7:0] pend_byte = 8'h00;
   logic hold = 1'b0;
   int   en_mode = 0;
   logic vld2_on = 1'b0;
   int   v2_hi = 0, rd2_cnt = 0, first_rd2 = 0, bad2 = 0;

   task automatic chk(input string nm, input int act, input int expv);
      nchk++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      tcyc++;
      data_out = pend_valid ? pend_byte : 8'($urandom);
      case (en_mode)
         0:       enable = 1'b1;
         1:       enable = ((tcyc / 3) % 2) == 0;
         default: enable = ($urandom_range(0, 3) != 0);
      endcase
      hold = (en_mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
      vld_out = (fifo.size() != 0) && !hold;
      vld2 = vld2_on && (rd2_cnt < 2);
   endtask

   task automatic push_pkt(input logic [1:0] addr, input int len, input bit seq,
                           input logic [7:0] par_x, input int keep);
      logic [7:0] b, par;
      ev_t e;
      b = {6'(len), addr};
      fifo.push_back(b);
      par = b;
      e.kind = 0; e.a = {6'b0, addr}; e.b = 8'(len);
      exp_q.push_back(e);
      for (int i = 0; i < len; i++) begin
         if (keep >= 0 && i >= keep) break;
         b = seq ? 8'(i + 1) : 8'($urandom);
         fifo.push_back(b);
         par ^= b;
         e.kind = 1; e.a = b; e.b = 8'h00;
         exp_q.push_back(e);
      end
      if (keep >= 0) begin
         e.kind = 3; e.a = 8'h00; e.b = 8'h00;
         exp_q.push_back(e);
      end else begin
         fifo.push_back(par ^ par_x);
         e.kind = 2; e.a = {7'b0, par_x != 8'h00}; e.b = 8'h00;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0)
         chk("wait_bound", exp_q.size(), 0);
      repeat (3) tick();
   endtask

   // FIFO side: a read at this edge returns its byte on the following cycle
   always @(posedge clk) begin
      rst_q = reset;
      if (read_enb) begin
         nrd++;
         chk("rd_needs_vld", 32'(vld_out), 1);
         if (fifo.size() != 0) begin
            pend_byte = fifo.pop_front();
            pend_valid = 1'b1;
         end else begin
            pend_valid = 1'b0;
         end
      end else begin
         pend_valid = 1'b0;
      end
      if (vld2)
         v2_hi++;
      if (read_enb2) begin
         chk("rd2_needs_vld", 32'(vld2), 1);
         rd2_cnt++;
         if (rd2_cnt == 1)
            first_rd2 = v2_hi;
      end
      if (timeout_err2 || parity_err2 || pld_valid2)
         bad2++;
   end

   // Compare process: every output pulse must match the next expected event
   always @(negedge clk) begin
      ev_t e;
      int  n;
      ccyc++;
      if (rst_q) begin
         chk("reset_outs", 32'({read_enb, pkt_start, hdr_addr, hdr_len, pld_data,
                                pld_valid, pkt_done, parity_err, timeout_err}), 0);
         chk("reset_cnts", 32'({pkt_cnt, err_cnt}), 0);
         exp_q.delete();
         m_pkt = 0; m_err = 0; m_addr = 2'd0; m_len = 6'd0;
      end else begin
         n = int'(pkt_start) + int'(pld_valid) + int'(pkt_done) + int'(timeout_err);
         if (parity_err && !pkt_done)
            chk("perr_without_done", 32'(parity_err), 0);
         if (n > 1) begin
            chk("one_event_per_cycle", n, 1);
         end else if (n == 1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", n, 0);
            end else begin
               e = exp_q.pop_front();
               if (pkt_start) begin
                  chk("ev_start", e.kind, 0);
                  chk("hdr_addr", 32'(hdr_addr), 32'(e.a));
                  chk("hdr_len", 32'(hdr_len), 32'(e.b));
                  m_addr = e.a[1:0];
                  m_len = e.b[5:0];
               end else if (pld_valid) begin
                  chk("ev_pld", e.kind, 1);
                  chk("pld_data", 32'(pld_data), 32'(e.a));
                  npld++;
               end else if (pkt_done) begin
                  chk("ev_done", e.kind, 2);
                  chk("parity_err", 32'(parity_err), 32'(e.a));
               end else begin
                  chk("ev_timeout", e.kind, 3);
                  chk("timeout_gap", ccyc - last_ev, TMO);
               end
               if (e.kind == 2) begin
                  m_pkt = (m_pkt + 1) % 65536;
                  if (e.a[0] && m_err < 255) m_err++;
               end
               if (e.kind == 3 && m_err < 255) m_err++;
               last_ev = ccyc;
            end
         end
         chk("pkt_cnt", 32'(pkt_cnt), m_pkt);
         chk("err_cnt", 32'(err_cnt), m_err);
         chk("hdr_hold", 32'({hdr_addr, hdr_len}), 32'({m_addr, m_len}));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, p0, n;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // router soft-resets before the delayed reader qualifies
      vld2_on = 1'b1;
      repeat (router_pkg::SOFT_RST_CYC) tick();
      vld2_on = 1'b0;
      repeat (40) tick();
      chk("sd_no_read", rd2_cnt, 0);
      chk("sd_no_err", 32'(err_cnt2) + bad2 + 32'(pkt_start2), 0);
      // vld held long enough: header then parity of an all-zero len-0 packet
      v2_hi = 0;
      vld2_on = 1'b1;
      n = 0;
      while (rd2_cnt < 2 && n < 100) begin
         tick();
         n++;
      end
      vld2_on = 1'b0;
      repeat (10) tick();
      chk("sd_first_rd_late", 32'(first_rd2 > 31), 1);
      chk("sd_first_rd_bound", 32'(first_rd2 <= 33), 1);
      chk("sd_reads", rd2_cnt, 2);
      chk("sd_pkt_cnt", 32'(pkt_cnt2), 1);
      chk("sd_clean", 32'(err_cnt2) + bad2, 0);
      chk("sd_hdr", 32'({hdr_addr2, hdr_len2, pld_data2}), 0);

      // 8'h16 + 01..05 + 17, then the same packet with parity 00
      r0 = nrd;
      push_pkt(2'd2, 5, 1'b1, 8'h00, -1);
      push_pkt(2'd2, 5, 1'b1, 8'h17, -1);
      wait_done(500);
      chk("rd_count_pkt12", nrd - r0, 14);
      chk("lit_pkt_cnt_12", 32'(pkt_cnt), 2);
      chk("lit_err_cnt_12", 32'(err_cnt), 1);

      // len 0: header 8'h01 then parity 8'h01
      r0 = nrd;
      push_pkt(2'd1, 0, 1'b1, 8'h00, -1);
      wait_done(200);
      chk("rd_count_len0", nrd - r0, 2);
      chk("lit_pkt_cnt_len0", 32'(pkt_cnt), 3);

      // only 2 of 5 payload bytes ever arrive
      r0 = nrd;
      push_pkt(2'd2, 5, 1'b1, 8'h00, 2);
      wait_done(300);
      chk("rd_count_trunc", nrd - r0, 3);
      chk("lit_pkt_cnt_trunc", 32'(pkt_cnt), 3);
      chk("lit_err_cnt_trunc", 32'(err_cnt), 2);

      // enable toggled every 3 cycles over a len-10 packet
      en_mode = 1;
      r0 = nrd;
      push_pkt(2'd3, 10, 1'b0, 8'h00, -1);
      wait_done(500);
      en_mode = 0;
      chk("rd_count_toggle", nrd - r0, 12);
      chk("lit_pkt_cnt_toggle", 32'(pkt_cnt), 4);

      // reset in the middle of a payload, then a clean packet
      p0 = npld;
      push_pkt(2'd0, 20, 1'b0, 8'h00, -1);
      n = 0;
      while (npld - p0 < 5 && n < 200) begin
         tick();
         n++;
      end
      chk("reached_body", 32'(npld - p0 >= 5), 1);
      reset = 1'b1;
      fifo.delete();
      tick();
      reset = 1'b0;
      repeat (3) tick();
      push_pkt(2'd1, 7, 1'b0, 8'h00, -1);
      wait_done(300);
      chk("lit_pkt_cnt_post_rst", 32'(pkt_cnt), 1);
      chk("lit_err_cnt_post_rst", 32'(err_cnt), 0);

      // random packets with random enable and vld stalls
      en_mode = 2;
      for (int k = 0; k < 30; k++) begin
         push_pkt(2'($urandom_range(0, 3)), $urandom_range(0, 40), 1'b0,
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, -1);
         repeat ($urandom_range(0, 20)) tick();
      end
      wait_done(20000);
      en_mode = 0;
      repeat (5) tick();
      chk("fifo_drained", fifo.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/router_pkt_reader.md
Name: router_pkt_reader

Overview:
Destination-side packet consumer for one router output port; it is the read end of a router FIFO. It watches vld_out, drives read_enb, and parses the byte stream from data_out into a packet. The packet is a header (addr[1:0], len[7:2]), then len payload bytes, then one parity byte. It reports payload bytes, end-of-packet, parity errors and stall timeouts to the destination client. An optional start delay lets the bench drive the router's 30-cycle soft-reset path.

Parameters:
START_DELAY, 0, cycles vld_out must stay high in IDLE before the header read is issued (0..63)
TIMEOUT, 32, idle cycles allowed mid-packet before abort (2..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
vld_out  in  1  FIFO not-empty from router
data_out  in  8  FIFO read data; valid the cycle after an accepted read_enb
enable  in  1  client permits new reads; in-flight bytes are still accepted
read_enb  out  1  FIFO read strobe
pkt_start  out  1  1-cycle pulse when the header byte is captured
hdr_addr  out  2  header bits [1:0], held until next header
hdr_len  out  6  header bits [7:2], held until next header
pld_data  out  8  payload byte
pld_valid  out  1  1-cycle qualifier for pld_data (payload only, never header or parity)
pkt_done  out  1  1-cycle pulse when the parity byte is captured
parity_err  out  1  1-cycle pulse coincident with pkt_done on mismatch
timeout_err  out  1  1-cycle pulse on abort
pkt_cnt  out  16  completed packets, wraps at 2^16
err_cnt  out  8  parity plus timeout errors, saturates at 255

Behaviour:
- Reset (sync, active-high): all outputs 0, FSM to IDLE, all counters and accumulators 0. Any in-flight byte is discarded. Reset mid-packet gives the same result.
- Read latency: read_enb at cycle t returns its byte on data_out at t+1. A 1-bit rx_pend flop marks t+1 as a capture cycle.
- read_enb is registered-free combinational: state permits && vld_out && enable && requests outstanding. read_enb is never asserted while vld_out=0.
- FSM states:
  - IDLE: delay counter increments while vld_out=1 and clears when vld_out=0. Go to HDR_REQ when the count reaches START_DELAY (immediately if START_DELAY=0).
  - HDR_REQ: issue exactly one read, then go to HDR_WAIT.
  - HDR_WAIT: on capture, latch hdr_addr/hdr_len, pulse pkt_start, set parity accumulator = header byte, set req_left = rx_left = hdr_len+1 (7-bit), go to BODY.
  - BODY: each issued read decrements req_left, and reads stop at req_left=0 (never over-read). Each capture decrements rx_left. When rx_left>1, the captured byte is payload: pld_valid=1 and it is XORed into the accumulator. When rx_left=1, the byte is parity: pulse pkt_done, and pulse parity_err if byte != accumulator. Go to IDLE the next cycle.
- len=0: the header is followed directly by parity, with no pld_valid.
- Back-to-back packets: after pkt_done, IDLE waits for a fresh START_DELAY qualification. The next packet's bytes are never read early.
- Timeout: in HDR_WAIT/BODY, an idle counter increments on cycles with neither a read issued nor a capture, and clears on either. At TIMEOUT it pulses timeout_err, goes to IDLE, and discards the partial packet (no pkt_done). This covers FIFO soft-reset mid-packet.
- enable=0 mid-packet: reads pause and the timeout still counts. The single in-flight byte is still captured.
- Counters: pkt_cnt increments on every pkt_done, including those with a parity error. err_cnt increments on parity_err or timeout_err, which are never simultaneous.
- data_out may be Z/X when no capture is pending. It must be ignored then.

Decomposition:
- Shared package router_pkg holds: state enum (IDLE, HDR_REQ, HDR_WAIT, BODY), header field positions (ADDR_LSB=0, LEN_LSB=2, LEN_W=6), and the router soft-reset window constant (30).
- Natural sub-module: router_pkt_checker, which holds the parity accumulator, the compare, and pkt_cnt/err_cnt. The FSM and read control stay in the top.

Test Plan:
- Header 8'h16 (len 5, addr 2), payload 01..05, parity 8'h17 → 5 pld_valid pulses 01..05, pkt_done, parity_err=0, pkt_cnt=1, exactly 7 read_enb cycles.
- Same packet with parity 8'h00 → pkt_done with parity_err=1, err_cnt=1, pkt_cnt=1.
- Header 8'h01 (len 0, addr 1), parity 8'h01 → pkt_start, then pkt_done next capture, no pld_valid.
- vld_out drops after 2 of 5 payload bytes and stays low → timeout_err exactly TIMEOUT=32 cycles after the last capture, no pkt_done, FSM IDLE, err_cnt=1.
- START_DELAY=31 with vld_out high → no read_enb for 31 cycles. With the router soft-resetting at 30, vld_out falls, and the reader stays IDLE with no errors.
- enable toggled every 3 cycles over a len-10 packet, plus reset asserted mid-BODY in a second run → first run gives payload order intact with no extra reads; second run gives all outputs 0 the next cycle and the next packet parses cleanly.
